// File: rtl/johnson_decoder.sv
// johnson_decoder: converts Johnson codes to a binary phase index, checks sequence and tracks lock.
module johnson_decoder #(
  parameter int WIDTH = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W = 8,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  output logic [IDX_W-1:0] idx,
  output logic             legal,
  output logic             step_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] ref_idx, ref_n, dec, exp_idx;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic lgl, good, err, serr;
  int p;
  always_comb begin
    p = $countones(din);
    lgl = din == ~({WIDTH{1'b1}} >> p) || din == ({WIDTH{1'b1}} >> (WIDTH - p));
    dec = !lgl ? '0 : (din[WIDTH-1] || din == '0) ? IDX_W'(p) : IDX_W'(2 * WIDTH - p);
    exp_idx = ref_idx == IDX_W'(2 * WIDTH - 1) ? '0 : ref_idx + 1'b1;
    good = lgl && dec == exp_idx;
    state_n = state;
    ref_n = ref_idx;
    cnt_n = cnt;
    err = 1'b0;
    serr = 1'b0;
    if (in_valid) begin
      if (!lgl) begin
        state_n = UNLOCKED;
        err = 1'b1;
        serr = state == LOCKED;
      end else begin
        ref_n = dec;
        case (state)
          UNLOCKED: begin
            cnt_n = '0;
            state_n = ACQUIRE;
          end
          ACQUIRE: begin
            cnt_n = good ? cnt + 1'b1 : '0;
            state_n = good && cnt + 1'b1 == CNT_W'(LOCK_CNT) ? LOCKED : ACQUIRE;
          end
          LOCKED: begin
            serr = !good;
            err = !good;
            cnt_n = good ? cnt : '0;
            state_n = good ? LOCKED : ACQUIRE;
          end
          default: state_n = UNLOCKED;
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= UNLOCKED;
      ref_idx <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      idx <= '0;
      legal <= 1'b0;
      step_err <= 1'b0;
      locked <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      ref_idx <= ref_n;
      cnt <= cnt_n;
      out_valid <= in_valid;
      step_err <= serr;
      locked <= state_n == LOCKED;
      if (in_valid) begin
        idx <= dec;
        legal <= lgl;
      end
      if (err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: directed and random stimulus against a table-driven reference model.
module tb_johnson_decoder;
  localparam int W = 4;
  localparam int N = 2 * W;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic out_valid, legal, step_err, locked;
  logic [2:0] idx;
  logic [7:0] err_cnt;
  logic ov2, lg2, se2, lk2;
  logic [2:0] idx2;
  logic [1:0] err2;
  int npass = 0, ntot = 0;
  int m_state = 0, m_ref = 0, m_cnt = 0, m_err = 0, m_err2 = 0;
  int e_ov = 0, e_idx = 0, e_legal = 0, e_se = 0, e_lock = 0;

  johnson_decoder dut (.clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .out_valid(out_valid),
    .idx(idx), .legal(legal), .step_err(step_err), .locked(locked), .err_cnt(err_cnt));
  johnson_decoder #(.ERR_W(2)) dut2 (.clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
    .out_valid(ov2), .idx(idx2), .legal(lg2), .step_err(se2), .locked(lk2), .err_cnt(err2));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] code(input int k);
    logic [W-1:0] ones = '1;
    return k <= W ? ~(ones >> k) : ones >> (k - W);
  endfunction

  function automatic int find(input logic [W-1:0] d);
    for (int k = 0; k < N; k++) if (code(k) == d) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    ntot++;
    if (got === want) npass++;
    else $display("FAIL %s got %0d expected %0d at %0t", tag, got, want, $time);
  endtask

  task automatic model(input bit r, input bit v, input logic [W-1:0] d);
    int k;
    bit good;
    if (!r) begin
      {m_state, m_ref, m_cnt, m_err, m_err2} = '0;
      {e_ov, e_idx, e_legal, e_se, e_lock} = '0;
      return;
    end
    e_ov = v;
    e_se = 0;
    if (v) begin
      k = find(d);
      if (k < 0) begin
        e_legal = 0;
        e_idx = 0;
        e_se = m_state == 2;
        m_err = m_err < 255 ? m_err + 1 : m_err;
        m_err2 = m_err2 < 3 ? m_err2 + 1 : m_err2;
        m_state = 0;
      end else begin
        e_legal = 1;
        e_idx = k;
        good = k == (m_ref + 1) % N;
        if (m_state == 0) begin
          m_cnt = 0;
          m_state = 1;
        end else if (m_state == 1) begin
          m_cnt = good ? m_cnt + 1 : 0;
          if (m_cnt == 3) m_state = 2;
        end else if (!good) begin
          e_se = 1;
          m_err = m_err < 255 ? m_err + 1 : m_err;
          m_err2 = m_err2 < 3 ? m_err2 + 1 : m_err2;
          m_cnt = 0;
          m_state = 1;
        end
        m_ref = k;
      end
    end
    e_lock = m_state == 2;
  endtask

  task automatic cyc(input bit r, input bit v, input logic [W-1:0] d);
    rst = r;
    in_valid = v;
    din = d;
    @(posedge clk);
    model(r, v, d);
    #1;
    chk("out_valid", out_valid, e_ov);
    chk("idx", idx, e_idx);
    chk("legal", legal, e_legal);
    chk("step_err", step_err, e_se);
    chk("locked", locked, e_lock);
    chk("err_cnt", err_cnt, m_err);
    chk("err_cnt_w2", err2, m_err2);
  endtask

  initial begin
    cyc(0, 1, 4'b1000);
    cyc(0, 0, 4'b0000);
    for (int k = 0; k < N; k++) cyc(1, 1, code(k));
    for (int k = 0; k < 4; k++) cyc(1, 1, code(k));
    cyc(1, 1, 4'b1111);
    cyc(1, 1, 4'b0000);
    for (int k = 1; k < 4; k++) cyc(1, 1, code(k));
    cyc(1, 1, 4'b1010);
    cyc(1, 1, 4'b0000);
    for (int k = 1; k < 2 * N; k++) begin
      cyc(1, 1, code(k % N));
      cyc(1, 0, 4'b0101);
    end
    for (int k = 0; k < 5; k++) cyc(1, 1, k[0] ? 4'b0110 : 4'b1001);
    for (int k = 0; k < 6; k++) cyc(1, 1, code(k));
    cyc(0, 1, code(6));
    for (int k = 7; k < 12; k++) cyc(1, 1, code(k % N));
    for (int i = 0; i < 2000; i++) begin
      int sel = $urandom_range(0, 9);
      logic [W-1:0] d;
      d = sel < 7 ? code((m_ref + 1) % N) : sel < 9 ? code($urandom_range(0, N - 1)) : W'($urandom);
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, d);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the Johnson (twisted-ring) counter. The block samples a WIDTH-bit Johnson code each valid cycle and converts it to a binary phase index. It checks that the code is legal and that successive samples advance by exactly one phase, tracks lock with a small state machine, and keeps a saturating error count. It sits downstream of any Johnson-counter output, either a local counter or a registered copy of a remote one, as a monitor and binary converter.

## Interface
- WIDTH, 4: Johnson code width; even, ≥ 2; gives 2·WIDTH phases.
- LOCK_CNT, 3: consecutive correct steps required to declare lock; ≥ 1.
- ERR_W, 8: error counter width.
- IDX_W, $clog2(2·WIDTH): index width (derived, not overridden).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- in_valid  input  1  din is sampled this cycle.
- din  input  WIDTH  Johnson code; bit WIDTH-1 is the stage fed by ~bit 0.
- out_valid  output  1  registered copy of in_valid.
- idx  output  IDX_W  decoded phase of the last valid sample.
- legal  output  1  last valid sample was a legal Johnson code.
- step_err  output  1  one-cycle pulse: the last valid sample broke the sequence.
- locked  output  1  sequence-lock status.
- err_cnt  output  ERR_W  saturating count of errors.

## Operation
- Phase order for WIDTH=4: 0000→1000→1100→1110→1111→0111→0011→0001→0000. These are idx 0..7.
- Legal code: all ones contiguous from the MSB (1…10…0, including 0000), or all ones contiguous from the LSB (0…01…1). There are 2·WIDTH legal codes and all others are illegal.
- Decode rule: p = popcount(din).
  - If din[WIDTH-1]=1 or din=0, then idx = p.
  - Otherwise idx = 2·WIDTH − p.
  - Illegal code: idx = 0.
- Expected next index: exp = (ref + 1) mod 2·WIDTH, where ref is the index of the previous legal valid sample.
- Good step: a legal sample with idx == exp.
- FSM states are UNLOCKED, ACQUIRE and LOCKED. Transitions apply only when in_valid=1; with in_valid=0, state, ref and counters hold.
  - UNLOCKED, legal sample: ref ← idx, good-step count ← 0, go to ACQUIRE.
  - ACQUIRE, good step: ref ← idx, count+1. When the count reaches LOCK_CNT, go to LOCKED.
  - ACQUIRE, legal sample but wrong step: ref ← idx, count ← 0, stay in ACQUIRE. No error is counted.
  - LOCKED, good step: ref ← idx, stay in LOCKED.
  - LOCKED, legal sample but wrong step (including a repeated code): step_err pulses, err_cnt+1, ref ← idx, count ← 0, go to ACQUIRE.
  - Any state, illegal sample: legal=0, err_cnt+1, go to UNLOCKED. step_err pulses only if the state was LOCKED.
- err_cnt saturates at 2^ERR_W − 1 and never wraps. It is cleared only by reset.
- When out_valid=0: idx and legal hold their previous values, and step_err=0.

## Timing
- Latency is 1 cycle. A sample taken at edge N appears on idx, legal and step_err, with out_valid=1, after edge N.
- locked and err_cnt update on the same edge as the sample that changes them. locked rises in the output cycle of the LOCK_CNT-th good step, and falls in the output cycle of the erroring sample.
- Wrap-around: the step from the last phase (0001 for WIDTH=4) to phase 0 (0000) is a good step.
- Back-to-back valid samples on every cycle are supported with no bubbles.
- Reset (rst=0 at an edge) wins over everything, including mid-acquire or mid-lock. After that edge:
  - out_valid=0, idx=0, legal=0, step_err=0, locked=0, err_cnt=0;
  - state=UNLOCKED, ref=0, count=0.
- A sample presented on a reset edge is discarded.

## Test plan
- Reset, then feed the 8 legal codes 0000..0001 in order at WIDTH=4 → idx 0,1,…,7 one cycle later. legal=1 throughout. locked rises on the output of the 4th sample (1110, idx 3). err_cnt=0.
- Locked, then send 1111 followed by 0000 → step_err pulses once on the 0000 output. err_cnt=1, locked=0. After 3 further good steps (1000, 1100, 1110), locked=1.
- Locked, then send illegal code 1010 → legal=0, idx=0, step_err=1, err_cnt+1, locked=0. Next legal sample leaves locked=0 (ACQUIRE entered).
- Run a full sequence with in_valid toggling 1,0,1,0 → out_valid mirrors it delayed by 1. Lock is reached after 3 good steps, with idle cycles not counted. No errors.
- ERR_W=2, send 5 illegal codes → err_cnt goes 1,2,3,3,3.
- Locked at idx 5, assert rst=0 for one cycle while valid data continues → all outputs 0 on the reset output cycle. Re-acquisition starts from the next sample and reaches locked after 3 good steps.
